spi_slave_rx_12bit: RTL

//  SPI mode-0 receiver that sits directly downstream of the SPI source selector.

---
 rtl/spi_slave_rx_12bit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx_12bit.sv
// SPI mode-0 receiver. CS/SCLK/MOSI arrive asynchronously and are oversampled
// in the CLK domain. One MSB-first word is shifted in per CS-low frame, and the
// word is published with a one-cycle DATA_VALID strobe. Frames with the wrong
// bit count and frames that stall past the 1kHz-tick timeout raise FRAME_ERR
// instead of updating DATA.
module spi_slave_rx_12bit #(
  parameter int          WORD_BITS  = 12,
  parameter logic [15:0] TIMEOUT_MS = 16'd50
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLK_1kHz,
  input  logic                 CS_IN,
  input  logic                 SCLK_IN,
  input  logic                 MOSI_IN,
  output logic [WORD_BITS-1:0] DATA,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int             CW       = $clog2(WORD_BITS + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WORD_BITS);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(WORD_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  // [0],[1] = two-flop synchroniser, [2] = previous value for edge detect
  logic [2:0] cs_q, sclk_q, mosi_q, tk_q;
  logic       cs_fall_q, cs_rise_q, sclk_rise_q, tick_q;
  logic [1:0] settle_q;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            timer_q, timer_d;
  logic [WORD_BITS-1:0]   data_q, data_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;
  logic                   busy_q, busy_d;
  logic                   timeout;

  // Synchronise the async inputs; CS resets high so release gives no false edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 3'b000;
      tk_q   <= 3'b000;
    end else begin
      cs_q   <= {cs_q[1:0], CS_IN};
      sclk_q <= {sclk_q[1:0], SCLK_IN};
      mosi_q <= {mosi_q[1:0], MOSI_IN};
      tk_q   <= {tk_q[1:0], CLK_1kHz};
    end
  end

  // Registered edge pulses; mosi_q[2] lines up with sclk_rise_q in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cs_fall_q   <= cs_q[2] & ~cs_q[1];
      cs_rise_q   <= ~cs_q[2] & cs_q[1];
      sclk_rise_q <= ~sclk_q[2] & sclk_q[1];
      tick_q      <= ~tk_q[2] & tk_q[1];
    end
  end

  // After reset the synchronised CS still shows its reset value for a few
  // cycles; WAIT_IDLE must not trust it until real samples have arrived, or a
  // frame in progress across reset would be picked up part-way through.
  always_ff @(posedge CLK) begin
    if (RST)                 settle_q <= 2'd0;
    else if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
  end

  assign timeout = tick_q && (timer_q == TIMEOUT_MS - 16'd1);

  // Next-state and datapath; in SHIFT: cs_rise > timeout > sclk_rise > tick
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (settle_q == 2'd3 && cs_q[1]) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall_q) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            data_d = shreg_q;
            dv_d   = 1'b1;
          end else if (cnt_q != '0) begin
            fe_d = 1'b1;
          end
        end else if (timeout) begin
          fe_d    = 1'b1;
          state_d = WAIT_IDLE;
        end else if (sclk_rise_q) begin
          shreg_d = {shreg_q[WORD_BITS-2:0], mosi_q[2]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          timer_d = '0;
        end else if (tick_q) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = dv_q;
  assign FRAME_ERR  = fe_q;
  assign BUSY       = busy_q;

endmodule
